// File: rtl/alu_arbiter_pkg.sv
// Shared ALU opcodes and arbiter FSM encodings for alu_arbiter.
package alu_arbiter_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr_i, wrapping.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int   j_s;
  logic hit_s;

  // Scan from the pointer upwards; only the first hit is granted.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j_s   = 0;
    hit_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      j_s        = (int'(ptr_i) + k) % N;
      hit_s      = req_i[j_s] & ~any_o;
      gnt_o[j_s] = hit_s;
      idx_o      = hit_s ? IW'(j_s) : idx_o;
      any_o      = any_o | hit_s;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters.
// Optional owner lock for multi-op sequences when ALU_ARB_LOCK_EN is defined.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
  input  logic [NUM_REQ*3-1:0]     req_ctrl_i,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]       req_lock_i,
`endif
  output logic [WIDTH-1:0]         alu_a_o,
  output logic [WIDTH-1:0]         alu_b_o,
  output logic [2:0]               alu_ctrl_o,
  input  logic [WIDTH-1:0]         alu_result_i,
  input  logic                     alu_z_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [ID_W-1:0]          rsp_id_o,
  output logic [WIDTH-1:0]         rsp_result_o,
  output logic                     rsp_zero_o
);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d, id_q, id_d, next_id_s, win_s;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic             zero_q, zero_d, any_s;
  logic [NUM_REQ-1:0] elig_s, gnt_s;

  assign next_id_s = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;

`ifdef ALU_ARB_LOCK_EN
  logic lock_q, lock_d, op_lock_q, op_lock_d;

  // While locked only the owning requester is eligible.
  always_comb begin
    elig_s = lock_q ? (req_valid_i & ({{(NUM_REQ-1){1'b0}}, 1'b1} << id_q)) : req_valid_i;
  end

  // Lock state: current lock and the lock request of the op in flight.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lock_q    <= 1'b0;
      op_lock_q <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      op_lock_q <= op_lock_d;
    end
  end
`else
  assign elig_s = req_valid_i;
`endif

  rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_rr_pick (
    .req_i (elig_s),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt_s),
    .idx_o (win_s),
    .any_o (any_s)
  );

  // Next-state, accept pulse and operand/result capture.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    ctrl_d      = ctrl_q;
    res_d       = res_q;
    zero_d      = zero_q;
    req_ready_o = '0;
`ifdef ALU_ARB_LOCK_EN
    lock_d      = lock_q;
    op_lock_d   = op_lock_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_s) begin
          req_ready_o = reset_i ? '0 : gnt_s;
          id_d        = win_s;
          a_d         = req_a_i[win_s*WIDTH +: WIDTH];
          b_d         = req_b_i[win_s*WIDTH +: WIDTH];
          ctrl_d      = req_ctrl_i[win_s*3 +: 3];
`ifdef ALU_ARB_LOCK_EN
          op_lock_d   = req_lock_i[win_s];
          lock_d      = lock_q | req_lock_i[win_s];
`endif
          state_d     = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        res_d   = alu_result_i;
        zero_d  = alu_z_i;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
`ifdef ALU_ARB_LOCK_EN
          // A locked op keeps the pointer; an unlocked op ends any lock and rotates.
          if (op_lock_q) begin
            rr_ptr_d = rr_ptr_q;
          end else begin
            rr_ptr_d = next_id_s;
            lock_d   = 1'b0;
          end
`else
          rr_ptr_d = next_id_s;
`endif
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, latched operands and registered response.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= 3'b000;
      res_q    <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctrl_q   <= ctrl_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
    end
  end

  assign alu_a_o      = a_q;
  assign alu_b_o      = b_q;
  assign alu_ctrl_o   = ctrl_q;
  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_id_o     = id_q;
  assign rsp_result_o = res_q;
  assign rsp_zero_o   = zero_q;

endmodule
